// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared state encoding and field width for the countdown timer
package countdown_timer_pkg;

  localparam int FIELD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_timer_mod_down_counter.sv
// rtl/countdown_timer_mod_down_counter.sv - modulo-MOD down counter with clamped load and borrow out
module mod_down_counter
  import countdown_timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_en,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic               borrow_out
);

  localparam logic [FIELD_W-1:0] MAX_VAL = FIELD_W'(MOD - 1);

  logic [FIELD_W-1:0] r_value;
  logic [FIELD_W-1:0] w_load_clamped;

  assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= w_load_clamped;
    end else if (dec_en) begin
      r_value <= (r_value == '0) ? MAX_VAL : r_value - 8'd1;
    end
  end

  // Combinational so a single tick can ripple sec -> min -> hour on the same edge.
  assign borrow_out = dec_en && (r_value == '0);
  assign value      = r_value;

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - h:m:s countdown timer with run/pause control and one-cycle expiry pulse
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int HOUR   = 5,
  parameter int MINUTE = 3,
  parameter int SECOND = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_hour,
  input  logic [7:0] load_minute,
  input  logic [7:0] load_second,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] cur_hour,
  output logic [7:0] cur_minute,
  output logic [7:0] cur_second,
  output logic       running,
  output logic       done,
  output logic       expired
);

  state_t r_state;
  state_t w_state_next;
  logic   r_running;
  logic   r_done;
  logic   r_expired;
  logic   w_expired_next;
  logic   w_dec;
  logic   w_sec_borrow;
  logic   w_min_borrow;
  logic   w_hour_borrow;
  logic   w_zero;
  logic   w_at_one;
  logic [FIELD_W-1:0] w_sec;
  logic [FIELD_W-1:0] w_min;
  logic [FIELD_W-1:0] w_hour;

  mod_down_counter #(.MOD(SECOND)) u_sec (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_en     (w_dec),
    .load       (load),
    .load_val   (load_second),
    .value      (w_sec),
    .borrow_out (w_sec_borrow)
  );

  mod_down_counter #(.MOD(MINUTE)) u_min (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_en     (w_sec_borrow),
    .load       (load),
    .load_val   (load_minute),
    .value      (w_min),
    .borrow_out (w_min_borrow)
  );

  mod_down_counter #(.MOD(HOUR)) u_hour (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_en     (w_min_borrow),
    .load       (load),
    .load_val   (load_hour),
    .value      (w_hour),
    .borrow_out (w_hour_borrow)
  );

  assign w_zero   = (w_hour == '0) && (w_min == '0) && (w_sec == '0);
  assign w_at_one = (w_hour == '0) && (w_min == '0) && (w_sec == 8'd1);

  always_comb begin
    w_state_next   = r_state;
    w_dec          = 1'b0;
    w_expired_next = 1'b0;
    if (load) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start && !w_zero) w_state_next = ST_RUN;
        end
        ST_RUN: begin
          // Pause wins over a coincident tick; that tick is lost.
          if (pause) begin
            w_state_next = ST_PAUSE;
          end else if (tick) begin
            w_dec = 1'b1;
            if (w_at_one) begin
              w_state_next   = ST_DONE;
              w_expired_next = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start) w_state_next = ST_RUN;
        end
        default: w_state_next = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUN);
      r_done    <= (w_state_next == ST_DONE);
      r_expired <= w_expired_next;
    end
  end

  // The hour counter never borrows in practice: RUN never decrements from 0:0:0.
  logic w_unused;
  assign w_unused = w_hour_borrow;

  assign cur_hour   = w_hour;
  assign cur_minute = w_min;
  assign cur_second = w_sec;
  assign running    = r_running;
  assign done       = r_done;
  assign expired    = r_expired;

endmodule
